// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: brings up an iCE40 SB_PLL40_PAD from the free-running
// reference oscillator. It pulses the PLL reset and waits for a stable LOCK.
// It then releases the system reset, re-sequences on lock loss, and gives up
// into FAIL (optionally bypassing the PLL) after repeated failed attempts.
module pll_lock_sequencer #(
    parameter int RESET_CYCLES        = 16,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRIES         = 3,
    parameter int BYPASS_ON_FAIL      = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       LOCK_IN,
    input  logic       REARM,
    output logic       PLL_RESETB,
    output logic       PLL_BYPASS,
    output logic       SYS_RST,
    output logic       LOCKED,
    output logic       FAULT,
    output logic [3:0] RETRY_CNT
);

    // One counter width covers every window, with a spare bit so nothing wraps.
    localparam int MAX_AB = (RESET_CYCLES > LOCK_STABLE_CYCLES) ? RESET_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_P  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);
    localparam logic             BYPASS_EN    = (BYPASS_ON_FAIL != 0);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [3:0]       retry_inc;
    logic             timeout;

    logic sync1_q, sync1_d;
    logic lock_s_q, lock_s_d;

    logic pll_resetb_q, pll_resetb_d;
    logic pll_bypass_q, pll_bypass_d;
    logic sys_rst_q, sys_rst_d;
    logic locked_q, locked_d;
    logic fault_q, fault_d;

    // Two-stage synchronizer input path; LOCK_IN is asynchronous to CLK.
    always_comb begin
        sync1_d  = LOCK_IN;
        lock_s_d = sync1_q;
    end

    // Next-state, counters and retry bookkeeping; outputs decode the next state
    // so that each registered output changes on the same edge as the state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scnt_d    = scnt_q;
        retry_d   = retry_q;
        timeout   = 1'b0;
        retry_inc = retry_q + 4'd1;

        case (state_q)
            ST_RESET: begin
                if (cnt_q == RESET_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    scnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (cnt_q >= TIMEOUT_LAST) begin
                    timeout = 1'b1;
                end else if (lock_s_q) begin
                    state_d = ST_STABLE;
                    scnt_d  = CNT_ONE;
                    cnt_d   = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STABLE: begin
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    scnt_d  = '0;
                    if (cnt_q < TIMEOUT_LAST) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (scnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    scnt_d  = '0;
                    retry_d = '0;
                end else if (cnt_q >= TIMEOUT_LAST) begin
                    timeout = 1'b1;
                end else begin
                    scnt_d = scnt_q + CNT_ONE;
                    cnt_d  = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                retry_d = '0;
                if (!lock_s_q) begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                    scnt_d  = '0;
                end
            end
            ST_FAIL: begin
                if (REARM) begin
                    state_d = ST_RESET;
                    cnt_d   = '0;
                    scnt_d  = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
                scnt_d  = '0;
            end
        endcase

        if (timeout) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            scnt_d  = '0;
            state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RESET;
        end

        pll_resetb_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) || (state_d == ST_RUN);
        pll_bypass_d = (state_d == ST_FAIL) && BYPASS_EN;
        sys_rst_d    = !((state_d == ST_RUN) || ((state_d == ST_FAIL) && BYPASS_EN));
        locked_d     = (state_d == ST_RUN);
        fault_d      = (state_d == ST_FAIL);
    end

    // State, counters, synchronizer and registered outputs with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_RESET;
            cnt_q        <= '0;
            scnt_q       <= '0;
            retry_q      <= '0;
            sync1_q      <= 1'b0;
            lock_s_q     <= 1'b0;
            pll_resetb_q <= 1'b0;
            pll_bypass_q <= 1'b0;
            sys_rst_q    <= 1'b1;
            locked_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            scnt_q       <= scnt_d;
            retry_q      <= retry_d;
            sync1_q      <= sync1_d;
            lock_s_q     <= lock_s_d;
            pll_resetb_q <= pll_resetb_d;
            pll_bypass_q <= pll_bypass_d;
            sys_rst_q    <= sys_rst_d;
            locked_q     <= locked_d;
            fault_q      <= fault_d;
        end
    end

    assign PLL_RESETB = pll_resetb_q;
    assign PLL_BYPASS = pll_bypass_q;
    assign SYS_RST    = sys_rst_q;
    assign LOCKED     = locked_q;
    assign FAULT      = fault_q;
    assign RETRY_CNT  = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed bench for pll_lock_sequencer. Two instances
// share all inputs, one with bypass-on-fail and one without. Expected output
// vectors are queued as each step is driven and compared after the edge.
module tb_pll_lock_sequencer;

    logic CLK = 1'b0;
    logic RST;
    logic LOCK_IN;
    logic REARM;

    logic       resetb_a, bypass_a, sysrst_a, locked_a, fault_a;
    logic [3:0] retry_a;
    logic       resetb_b, bypass_b, sysrst_b, locked_b, fault_b;
    logic [3:0] retry_b;

    logic [8:0] obs_a, obs_b;

    typedef struct {
        string      tag;
        logic [8:0] exp_a;
        logic [8:0] exp_b;
    } exp_t;

    exp_t scoreboard[$];
    int   checks = 0;
    int   errors = 0;

    // Free-running reference clock, 10 time units per period.
    always #5 CLK = ~CLK;

    pll_lock_sequencer #(
        .RESET_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES(2), .BYPASS_ON_FAIL(1)
    ) dut (
        .CLK(CLK), .RST(RST), .LOCK_IN(LOCK_IN), .REARM(REARM),
        .PLL_RESETB(resetb_a), .PLL_BYPASS(bypass_a), .SYS_RST(sysrst_a),
        .LOCKED(locked_a), .FAULT(fault_a), .RETRY_CNT(retry_a)
    );

    pll_lock_sequencer #(
        .RESET_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32),
        .MAX_RETRIES(2), .BYPASS_ON_FAIL(0)
    ) dut_nb (
        .CLK(CLK), .RST(RST), .LOCK_IN(LOCK_IN), .REARM(REARM),
        .PLL_RESETB(resetb_b), .PLL_BYPASS(bypass_b), .SYS_RST(sysrst_b),
        .LOCKED(locked_b), .FAULT(fault_b), .RETRY_CNT(retry_b)
    );

    assign obs_a = {resetb_a, bypass_a, sysrst_a, locked_a, fault_a, retry_a};
    assign obs_b = {resetb_b, bypass_b, sysrst_b, locked_b, fault_b, retry_b};

    function automatic logic [8:0] vec(input logic resetb, input logic bypass,
                                       input logic sysrst, input logic locked,
                                       input logic fault, input logic [3:0] retry);
        return {resetb, bypass, sysrst, locked, fault, retry};
    endfunction

    function automatic logic [8:0] v_reset(input logic [3:0] r);
        return vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, r);
    endfunction

    function automatic logic [8:0] v_wait(input logic [3:0] r);
        return vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, r);
    endfunction

    function automatic logic [8:0] v_run();
        return vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    endfunction

    function automatic logic [8:0] v_fail_bypass();
        return vec(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
    endfunction

    function automatic logic [8:0] v_fail_hold();
        return vec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2);
    endfunction

    task automatic applyStimulus(input logic rst, input logic lock, input logic rearm);
        RST     = rst;
        LOCK_IN = lock;
        REARM   = rearm;
        @(negedge CLK);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed 0 entries expected at least 1");
        end else begin
            e = scoreboard.pop_front();
            checks++;
            assert (obs_a === e.exp_a) else begin
                errors++;
                $error("[TB] FAIL %s bypass_dut: observed %b expected %b", e.tag, obs_a, e.exp_a);
            end
            checks++;
            assert (obs_b === e.exp_b) else begin
                errors++;
                $error("[TB] FAIL %s hold_dut: observed %b expected %b", e.tag, obs_b, e.exp_b);
            end
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic lock, input logic rearm,
                        input logic [8:0] ea, input logic [8:0] eb);
        exp_t e;
        e.tag   = tag;
        e.exp_a = ea;
        e.exp_b = eb;
        scoreboard.push_back(e);
        applyStimulus(rst, lock, rearm);
        checkOutput();
    endtask

    task automatic steps(input int n, input string tag, input logic lock, input logic [8:0] e);
        for (int i = 0; i < n; i++) begin
            step(tag, 1'b0, lock, 1'b0, e, e);
        end
    endtask

    task automatic nominalSequence(input string tag);
        steps(3, {tag, "_resetb_low"}, 1'b0, v_reset(4'd0));
        step({tag, "_resetb_rise"}, 1'b0, 1'b0, 1'b0, v_wait(4'd0), v_wait(4'd0));
        steps(4, {tag, "_wait_nolock"}, 1'b0, v_wait(4'd0));
        steps(9, {tag, "_stabilizing"}, 1'b1, v_wait(4'd0));
        step({tag, "_locked"}, 1'b0, 1'b1, 1'b0, v_run(), v_run());
    endtask

    // Directed scenario sequence, one edge per step.
    initial begin
        RST     = 1'b1;
        LOCK_IN = 1'b0;
        REARM   = 1'b0;

        step("reset_vals", 1'b1, 1'b0, 1'b0, v_reset(4'd0), v_reset(4'd0));
        step("reset_vals", 1'b1, 1'b0, 1'b0, v_reset(4'd0), v_reset(4'd0));

        nominalSequence("nominal");
        steps(2, "run_hold", 1'b1, v_run());

        step("loss_edge_n", 1'b0, 1'b0, 1'b0, v_run(), v_run());
        step("loss_edge_n1", 1'b0, 1'b0, 1'b0, v_run(), v_run());
        step("loss_edge_n2", 1'b0, 1'b0, 1'b0, v_reset(4'd0), v_reset(4'd0));
        steps(3, "loss_resetb_low", 1'b1, v_reset(4'd0));
        step("loss_resetb_rise", 1'b0, 1'b1, 1'b0, v_wait(4'd0), v_wait(4'd0));
        steps(7, "relock_stabilizing", 1'b1, v_wait(4'd0));
        step("relock_run", 1'b0, 1'b1, 1'b0, v_run(), v_run());

        step("rst_in_run", 1'b1, 1'b0, 1'b0, v_reset(4'd0), v_reset(4'd0));
        steps(3, "rst_run_restart", 1'b0, v_reset(4'd0));
        step("rst_run_wait", 1'b0, 1'b0, 1'b0, v_wait(4'd0), v_wait(4'd0));

        steps(5, "glitch_high", 1'b1, v_wait(4'd0));
        step("glitch_low", 1'b0, 1'b0, 1'b0, v_wait(4'd0), v_wait(4'd0));
        steps(9, "glitch_recount", 1'b1, v_wait(4'd0));
        step("glitch_locked", 1'b0, 1'b1, 1'b0, v_run(), v_run());

        step("rst_in_run2", 1'b1, 1'b0, 1'b0, v_reset(4'd0), v_reset(4'd0));
        steps(3, "rst_run2_restart", 1'b0, v_reset(4'd0));
        step("rst_run2_wait", 1'b0, 1'b0, 1'b0, v_wait(4'd0), v_wait(4'd0));
        steps(4, "enter_stable", 1'b1, v_wait(4'd0));
        step("rst_in_stable", 1'b1, 1'b1, 1'b0, v_reset(4'd0), v_reset(4'd0));
        steps(3, "rst_stable_restart", 1'b1, v_reset(4'd0));
        step("rst_stable_wait", 1'b0, 1'b1, 1'b0, v_wait(4'd0), v_wait(4'd0));
        steps(7, "rst_stable_relock", 1'b1, v_wait(4'd0));
        step("rst_stable_run", 1'b0, 1'b1, 1'b0, v_run(), v_run());

        step("exh_loss_n", 1'b0, 1'b0, 1'b0, v_run(), v_run());
        step("exh_loss_n1", 1'b0, 1'b0, 1'b0, v_run(), v_run());
        step("exh_loss_n2", 1'b0, 1'b0, 1'b0, v_reset(4'd0), v_reset(4'd0));
        steps(3, "exh_reset0", 1'b0, v_reset(4'd0));
        step("exh_wait0_start", 1'b0, 1'b0, 1'b0, v_wait(4'd0), v_wait(4'd0));
        steps(15, "exh_window0", 1'b0, v_wait(4'd0));
        step("rearm_ignored", 1'b0, 1'b0, 1'b1, v_wait(4'd0), v_wait(4'd0));
        steps(15, "exh_window0", 1'b0, v_wait(4'd0));
        step("exh_timeout1", 1'b0, 1'b0, 1'b0, v_reset(4'd1), v_reset(4'd1));
        steps(3, "exh_reset1", 1'b0, v_reset(4'd1));
        step("exh_wait1_start", 1'b0, 1'b0, 1'b0, v_wait(4'd1), v_wait(4'd1));
        steps(31, "exh_window1", 1'b0, v_wait(4'd1));
        step("exh_fail", 1'b0, 1'b0, 1'b0, v_fail_bypass(), v_fail_hold());
        for (int i = 0; i < 6; i++) begin
            step("fail_lock_ignored", 1'b0, (i % 2 == 0), 1'b0, v_fail_bypass(), v_fail_hold());
        end
        step("fail_hold", 1'b0, 1'b0, 1'b0, v_fail_bypass(), v_fail_hold());

        step("rearm", 1'b0, 1'b0, 1'b1, v_reset(4'd0), v_reset(4'd0));
        nominalSequence("after_rearm");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
